// File: rtl/reg_mux_pipe.sv
// Programmable-latency register chain (0..DEPTH stages) with per-item valid, occupancy and flush-on-reconfigure.
// Latency = lat_q enabled edges (0 = combinational bypass); no backpressure, ce stalls every stage.
module reg_mux_pipe #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             sclr,
  input  logic [LW-1:0]    lat_sel,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             out_valid,
  output logic [LW-1:0]    occupancy,
  output logic             drop,
  output logic             cfg_err
);

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [DEPTH:1][WIDTH-1:0] stage;
  logic [DEPTH:1]            vld;
  logic [LW-1:0]             lat_q;
  logic [LW-1:0]             eff_sel;
  logic                      range_err;
  logic                      lat_chg;
  logic                      any_vld;

  assign range_err = (lat_sel > DEPTH_L);
  assign eff_sel   = range_err ? DEPTH_L : lat_sel;
  assign lat_chg   = (eff_sel != lat_q);

  // Tap select by equality compare only, so lat_q can never index past DEPTH.
  always_comb begin
    dout      = din;
    out_valid = in_valid;
    occupancy = '0;
    any_vld   = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (LW'(k) <= lat_q) begin
        occupancy = occupancy + LW'(vld[k]);
        any_vld   = any_vld | vld[k];
      end
      if (LW'(k) == lat_q) begin
        dout      = stage[k];
        out_valid = vld[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
      vld   <= '0;
      lat_q <= '0;
      drop  <= 1'b0;
    end else if (sclr) begin
      stage <= '0;
      vld   <= '0;
      lat_q <= eff_sel;
      drop  <= 1'b0;
    end else if (lat_chg) begin
      // Flush valids but keep data; the incoming item is discarded silently.
      vld   <= '0;
      lat_q <= eff_sel;
      drop  <= any_vld;
    end else if (ce) begin
      stage[1] <= din;
      vld[1]   <= in_valid;
      for (int k = 2; k <= DEPTH; k++) begin
        stage[k] <= stage[k-1];
        vld[k]   <= vld[k-1];
      end
      drop <= 1'b0;
    end else begin
      drop <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
    end else if (range_err) begin
      cfg_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_mux_pipe.sv
// Directed-vector bench for reg_mux_pipe (WIDTH=18, DEPTH=4).
module tb_reg_mux_pipe;

  localparam int WIDTH = 18;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic             ce;
  logic             sclr;
  logic [LW-1:0]    lat_sel;
  logic             in_valid;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             out_valid;
  logic [LW-1:0]    occupancy;
  logic             drop;
  logic             cfg_err;

  int n_vec;
  int n_err;

  reg_mux_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .sclr      (sclr),
    .lat_sel   (lat_sel),
    .in_valid  (in_valid),
    .din       (din),
    .dout      (dout),
    .out_valid (out_valid),
    .occupancy (occupancy),
    .drop      (drop),
    .cfg_err   (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic v, input logic [WIDTH-1:0] d);
    in_valid = v;
    din      = d;
    cyc();
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    ce       = 1'b0;
    sclr     = 1'b0;
    lat_sel  = '0;
    in_valid = 1'b1;
    din      = 18'h155AA;

    // Reset state and combinational bypass
    #2;
    chk("rst_bypass_dout", 32'(dout), 32'h155AA);
    chk("rst_bypass_vld",  32'(out_valid), 32'd1);
    chk("rst_occ",         32'(occupancy), 32'd0);
    chk("rst_drop",        32'(drop), 32'd0);
    chk("rst_cfg_err",     32'(cfg_err), 32'd0);
    #1 rst_n = 1'b1;
    cyc();
    chk("bypass_dout", 32'(dout), 32'h155AA);

    // Fixed latency 3
    lat_sel = 3'd3; ce = 1'b1; in_valid = 1'b0;
    cyc();
    chk("l3_set_drop", 32'(drop), 32'd0);
    feed(1'b1, 18'd1);
    chk("l3_e1_vld", 32'(out_valid), 32'd0);
    feed(1'b1, 18'd2);
    chk("l3_e2_vld", 32'(out_valid), 32'd0);
    chk("l3_e2_occ", 32'(occupancy), 32'd2);
    feed(1'b1, 18'd3);
    chk("l3_out1",     32'(dout), 32'd1);
    chk("l3_out1_vld", 32'(out_valid), 32'd1);
    chk("l3_occ3",     32'(occupancy), 32'd3);
    feed(1'b1, 18'd4);
    chk("l3_out2", 32'(dout), 32'd2);
    feed(1'b0, 18'd0);
    chk("l3_out3",  32'(dout), 32'd3);
    chk("l3_occ_a", 32'(occupancy), 32'd2);
    feed(1'b0, 18'd0);
    chk("l3_out4",  32'(dout), 32'd4);
    chk("l3_occ_b", 32'(occupancy), 32'd1);
    feed(1'b0, 18'd0);
    chk("l3_drain_vld", 32'(out_valid), 32'd0);
    chk("l3_drain_occ", 32'(occupancy), 32'd0);

    // Latency 2 with ce gaps; item 4 sits in stage 4, beyond the old tap
    lat_sel = 3'd2;
    cyc();
    chk("l2_set_drop", 32'(drop), 32'd0);
    ce = 1'b1; feed(1'b1, 18'hA);
    chk("ce_e1_vld", 32'(out_valid), 32'd0);
    chk("ce_e1_occ", 32'(occupancy), 32'd1);
    ce = 1'b0; feed(1'b1, 18'hB);
    chk("ce_hold1_vld", 32'(out_valid), 32'd0);
    chk("ce_hold1_occ", 32'(occupancy), 32'd1);
    cyc();
    chk("ce_hold2_occ", 32'(occupancy), 32'd1);
    ce = 1'b1; feed(1'b1, 18'hB);
    chk("ce_outA",     32'(dout), 32'hA);
    chk("ce_outA_vld", 32'(out_valid), 32'd1);
    chk("ce_occ2",     32'(occupancy), 32'd2);
    ce = 1'b0; feed(1'b0, 18'h0);
    chk("ce_holdA", 32'(dout), 32'hA);
    ce = 1'b1; cyc();
    chk("ce_outB", 32'(dout), 32'hB);
    chk("ce_occ1", 32'(occupancy), 32'd1);
    cyc();

    // Latency change with three items in flight
    lat_sel = 3'd3;
    cyc();
    chk("l3b_set_drop", 32'(drop), 32'd0);
    feed(1'b1, 18'h11);
    feed(1'b1, 18'h22);
    feed(1'b1, 18'h33);
    chk("flight_out", 32'(dout), 32'h11);
    chk("flight_occ", 32'(occupancy), 32'd3);
    lat_sel = 3'd1; feed(1'b1, 18'h44);
    chk("chg_drop",     32'(drop), 32'd1);
    chk("chg_vld",      32'(out_valid), 32'd0);
    chk("chg_occ",      32'(occupancy), 32'd0);
    chk("chg_keepdata", 32'(dout), 32'h33);
    feed(1'b1, 18'h55);
    chk("chg_drop_end", 32'(drop), 32'd0);
    chk("chg_next",     32'(dout), 32'h55);
    chk("chg_next_vld", 32'(out_valid), 32'd1);
    feed(1'b0, 18'h0);
    lat_sel = 3'd3; cyc();
    chk("chg_empty_drop", 32'(drop), 32'd0);

    // sclr beats a latency change
    lat_sel = 3'd2; cyc();
    feed(1'b1, 18'h66);
    chk("pre_sclr_occ", 32'(occupancy), 32'd1);
    sclr = 1'b1; ce = 1'b0; lat_sel = 3'd4; in_valid = 1'b0;
    cyc();
    sclr = 1'b0;
    chk("sclr_drop", 32'(drop), 32'd0);
    chk("sclr_vld",  32'(out_valid), 32'd0);
    chk("sclr_occ",  32'(occupancy), 32'd0);
    chk("sclr_dout", 32'(dout), 32'd0);
    ce = 1'b1; feed(1'b1, 18'h77);
    feed(1'b0, 18'h0);
    feed(1'b0, 18'h0);
    chk("l4_e3_vld", 32'(out_valid), 32'd0);
    cyc();
    chk("l4_out", 32'(dout), 32'h77);
    chk("l4_vld", 32'(out_valid), 32'd1);

    // Out-of-range request clamps to DEPTH
    chk("pre_cfg_err", 32'(cfg_err), 32'd0);
    lat_sel = 3'd6; feed(1'b1, 18'h88);
    chk("oor_cfg_err", 32'(cfg_err), 32'd1);
    chk("oor_drop",    32'(drop), 32'd0);
    feed(1'b0, 18'h0);
    feed(1'b0, 18'h0);
    chk("oor_e3_vld", 32'(out_valid), 32'd0);
    cyc();
    chk("oor_out", 32'(dout), 32'h88);
    chk("oor_vld", 32'(out_valid), 32'd1);
    lat_sel = 3'd1; cyc();
    chk("oor_chg_drop", 32'(drop), 32'd1);
    chk("cfg_sticky",   32'(cfg_err), 32'd1);

    // Reset mid-stream
    feed(1'b1, 18'h99);
    chk("mid_out", 32'(dout), 32'h99);
    din = 18'h123; in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bypass", 32'(dout), 32'h123);
    chk("arst_vld",    32'(out_valid), 32'd0);
    chk("arst_occ",    32'(occupancy), 32'd0);
    chk("arst_cfg",    32'(cfg_err), 32'd0);
    chk("arst_drop",   32'(drop), 32'd0);
    #1 rst_n = 1'b1;
    ce = 1'b0; lat_sel = 3'd1;
    cyc();
    chk("arst_stage1", 32'(dout), 32'd0);
    chk("arst_drop2",  32'(drop), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_mux_pipe.md
Name: reg_mux_pipe

Overview:
- Parametrised successor to the single-stage register/bypass mux used on the DSP48A1 slice input and pipeline paths.
- Provides a chain of DEPTH registers with a runtime-selectable output tap (0 = combinational bypass, 1..DEPTH = registered latency).
- Adds clock enable, synchronous clear, per-item valid tracking, in-flight occupancy count, and safe latency reconfiguration that flushes stale items.
- Sits between slice operand ports (A/B/C/D/M/P paths) and downstream arithmetic wherever a programmable latency is needed.

Parameters:
- WIDTH, 18, data width in bits.
- DEPTH, 4, number of register stages; legal range 1..8.
- LW, $clog2(DEPTH+1), width of the latency-select and occupancy fields (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low; deassertion is synchronous to clk.
- ce  in  1  clock enable; advances the pipeline when 1.
- sclr  in  1  synchronous clear, independent of ce.
- lat_sel  in  LW  requested latency (tap index) 0..DEPTH.
- in_valid  in  1  din carries a valid item.
- din  in  WIDTH  input data.
- dout  out  WIDTH  data at the selected tap.
- out_valid  out  1  dout carries a valid item.
- occupancy  out  LW  number of valid items in stages 1..lat_q.
- drop  out  1  one-cycle pulse: a latency change discarded at least one valid item.
- cfg_err  out  1  sticky flag: lat_sel > DEPTH was seen.

Behaviour:
- Reset (rst_n=0, async):
  - stage[1..DEPTH] = 0 and vld[1..DEPTH] = 0.
  - lat_q = 0, drop = 0, cfg_err = 0, occupancy = 0.
  - dout = din and out_valid = in_valid, since the tap is 0.
- Priority at each rising clk edge: sclr > latency change > normal shift.
- sclr=1:
  - all stage and vld registers clear to 0 and drop is 0.
  - lat_q still updates to the clamped lat_sel.
  - cfg_err is unaffected.
- Clamping: eff_sel = (lat_sel > DEPTH) ? DEPTH : lat_sel. When lat_sel > DEPTH, cfg_err is set and stays set until reset.
- Latency change (sclr=0, eff_sel != lat_q), evaluated every cycle regardless of ce:
  - lat_q <= eff_sel.
  - all vld[1..DEPTH] clear to 0; data registers keep their contents.
  - drop <= OR of vld[1..old lat_q]; 0 if old lat_q = 0.
  - The pipeline does not shift in that cycle, even if ce=1; the din item presented that cycle is discarded without a drop pulse.
- Normal shift (sclr=0, no change, ce=1):
  - stage[1] <= din, vld[1] <= in_valid.
  - stage[k] <= stage[k-1] and vld[k] <= vld[k-1] for k = 2..DEPTH.
  - drop <= 0.
- ce=0 with no change: all stages and valids hold; drop <= 0.
- Output mux (combinational on lat_q):
  - lat_q = 0: dout = din, out_valid = in_valid.
  - otherwise: dout = stage[lat_q], out_valid = vld[lat_q].
  - Stages beyond lat_q keep shifting but are unobserved.
- occupancy: combinational popcount of vld[1..lat_q]; 0 when lat_q = 0.
- Latency with ce held 1: an item on din at edge n appears on dout after edge n+lat_q-1, i.e. it is visible in cycle n+lat_q.
- Enabled cycles only: with ce gaps, latency counts ce=1 edges, not clk edges.
- Reset mid-stream: all in-flight items are lost, with no drop pulse.
- X-safety: the tap mux must never index beyond DEPTH.

Test Plan:
- Reset then bypass: lat_sel=0, din=0x155AA, in_valid=1 -> dout=0x155AA and out_valid=1 in the same cycle; occupancy=0.
- Fixed latency: lat_sel=3, ce=1, feed din=1,2,3,4 with valid -> dout=1 first visible 3 cycles after the input edge; sequence 1,2,3,4 in order; occupancy reaches 3.
- CE gaps: lat_sel=2, ce pattern 1,0,0,1 while feeding 0xA then 0xB -> 0xA emerges only after the second enabled edge; held values are stable while ce=0.
- Latency change: 3 valid items in flight at lat 3, switch lat_sel to 1 -> drop pulses 1 cycle, out_valid=0, occupancy=0; next item emerges 1 enabled edge later. Repeat with an empty pipeline -> drop stays 0.
- sclr versus change: sclr=1 with lat_sel changed 2->4 and ce=0 -> all valids cleared, lat_q=4, drop=0.
- Out-of-range lat_sel (DEPTH=4, lat_sel=6) -> behaves as lat 4 and cfg_err=1. cfg_err stays 1 after lat_sel=1 and clears only on rst_n=0; asserting rst_n mid-stream clears dout taps to 0 asynchronously.
